// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pkg                                                      |
// | Description : Shared 640x480 raster timing constants, sync polarity,       |
// |               renderer cell sizes and a sync-level helper.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pkg;

  // Screen coordinate as carried on x/y and by the internal counters.
  typedef logic [9:0] coord_t;

  // Horizontal timing, in pixels.
  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

  // Vertical timing, in lines.
  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;
  localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

  // Sync pulses are active-low for this mode.
  localparam bit c_SYNC_POL = 1'b0;

  // Renderer cell geometry.
  localparam int c_WIDE = 213;
  localparam int c_HIGH = 160;

  // Drive level of a sync line: the polarity when active, its inverse otherwise.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_delay_line                                              |
// | Description : DEPTH-stage single-bit shift register with async reset of    |
// |               every stage to RST_VAL.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_delay_line #(
  parameter int DEPTH   = 2,
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DEPTH <= 1) begin : g_single
      logic r_q;

      // Single output flop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= RST_VAL;
        else     r_q <= i_d;
      end

      assign o_q = r_q;
    end else begin : g_shift
      logic [DEPTH-1:0] r_sr;

      // Shift towards the MSB; the MSB is the oldest sample.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sr <= {DEPTH{RST_VAL}};
        else     r_sr <= {r_sr[DEPTH-2:0], i_d};
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                               |
// | Description : Raster timing generator: pixel-rate divider, h/v counters,   |
// |               registered x/y/en, line/frame pulses and delayed syncs.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = c_H_ACTIVE,
  parameter int H_FP       = c_H_FP,
  parameter int H_SYNC     = c_H_SYNC,
  parameter int H_BP       = c_H_BP,
  parameter int V_ACTIVE   = c_V_ACTIVE,
  parameter int V_FP       = c_V_FP,
  parameter int V_SYNC     = c_V_SYNC,
  parameter int V_BP       = c_V_BP,
  parameter bit SYNC_POL   = c_SYNC_POL,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);

  localparam coord_t c_H_ACT   = 10'(H_ACTIVE);
  localparam coord_t c_H_MAX   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t c_HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam coord_t c_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t c_V_ACT   = 10'(V_ACTIVE);
  localparam coord_t c_V_MAX   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t c_VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam coord_t c_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t c_ONE     = 10'd1;

  // The sync delay is counted from x/y. With no extra delay one flop is
  // still kept so hsync/vsync remain registered outputs.
  localparam int c_SYNC_STAGES = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [c_DIV_W-1:0] w_div_next;
  logic               r_tick;
  coord_t             r_h_cnt;
  coord_t             r_v_cnt;
  coord_t             r_x;
  coord_t             r_y;
  logic               r_en;
  logic               r_line_start;
  logic               r_frame_start;
  logic               w_hs_raw;
  logic               w_vs_raw;

  assign w_div_next = (r_div_cnt == c_DIV_MAX) ? '0 : (r_div_cnt + c_DIV_ONE);

  // Clock divider; the tick flop is set for the clk in which div_cnt is at its last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_tick    <= (w_div_next == c_DIV_MAX);
    end
  end

  // On each tick: publish the current counters as x/y/en, then advance them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_en          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (r_tick) begin
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_en          <= (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
      r_line_start  <= (r_h_cnt == '0);
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      if (r_h_cnt == c_H_MAX) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_V_MAX) ? '0 : (r_v_cnt + c_ONE);
      end else begin
        r_h_cnt <= r_h_cnt + c_ONE;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // Sync windows are decoded from the published coordinates, so the delay
  // line lines them up with the renderer's colour pipeline behind x/y.
  assign w_hs_raw = sync_level((r_x >= c_HS_BEG) && (r_x < c_HS_END), SYNC_POL);
  assign w_vs_raw = sync_level((r_y >= c_VS_BEG) && (r_y < c_VS_END), SYNC_POL);

  sync_delay_line #(
    .DEPTH   (c_SYNC_STAGES),
    .RST_VAL (~SYNC_POL)
  ) u_hs_dly (
    .clk (clk),
    .rst (reset),
    .i_d (w_hs_raw),
    .o_q (hsync)
  );

  sync_delay_line #(
    .DEPTH   (c_SYNC_STAGES),
    .RST_VAL (~SYNC_POL)
  ) u_vs_dly (
    .clk (clk),
    .rst (reset),
    .i_d (w_vs_raw),
    .o_q (vsync)
  );

  assign x           = r_x;
  assign y           = r_y;
  assign en          = r_en;
  assign pixel_tick  = r_tick;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                            |
// | Description : Self-checking bench: default-timing DUT plus two shrunk-     |
// |               timing DUTs, compared against a closed-form raster model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       hs;
    logic       vs;
    logic       tk;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int d;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit pol;
    int sdel;
  } cfg_t;

  typedef struct {
    int   k;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] x_d, y_d, x_s, y_s, x_f, y_f;
  logic en_d, hs_d, vs_d, tk_d, ls_d, fs_d;
  logic en_s, hs_s, vs_s, tk_s, ls_s, fs_s;
  logic en_f, hs_f, vs_f, tk_f, ls_f, fs_f;
  obs_t ob_d, ob_s, ob_f;

  assign ob_d = {x_d, y_d, en_d, hs_d, vs_d, tk_d, ls_d, fs_d};
  assign ob_s = {x_s, y_s, en_s, hs_s, vs_s, tk_s, ls_s, fs_s};
  assign ob_f = {x_f, y_f, en_f, hs_f, vs_f, tk_f, ls_f, fs_f};

  vga_timing_gen u_dut_d (
    .clk(clk), .reset(reset), .x(x_d), .y(y_d), .en(en_d), .hsync(hs_d), .vsync(vs_d),
    .pixel_tick(tk_d), .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .SYNC_DELAY(2)
  ) u_dut_s (
    .clk(clk), .reset(reset), .x(x_s), .y(y_s), .en(en_s), .hsync(hs_s), .vsync(vs_s),
    .pixel_tick(tk_s), .line_start(ls_s), .frame_start(fs_s)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b1), .SYNC_DELAY(0)
  ) u_dut_f (
    .clk(clk), .reset(reset), .x(x_f), .y(y_f), .en(en_f), .hsync(hs_f), .vsync(vs_f),
    .pixel_tick(tk_f), .line_start(ls_f), .frame_start(fs_f)
  );

  cfg_t cfg_d, cfg_s, cfg_f;
  int   k;
  int   n_chk = 0;
  int   n_pass = 0;

  // ---------------- reference model (closed form in clk count k) ----------
  // k = number of clk edges since reset release.
  function automatic int ticks_before(cfg_t c, int kk);
    if (kk <= 0) return 0;
    if (c.d == 1) return kk - 1;
    return kk / c.d;
  endfunction

  function automatic bit is_tick(cfg_t c, int kk);
    return (kk >= 1) && ((kk % c.d) == (c.d - 1));
  endfunction

  function automatic void pix_at(cfg_t c, int kk, output int px, output int py, output bit pen);
    int t, p, ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    t  = ticks_before(c, kk);
    if (t == 0) begin
      px = 0; py = 0; pen = 1'b0;
    end else begin
      p   = t - 1;
      px  = p % ht;
      py  = (p / ht) % vt;
      pen = (px < c.ha) && (py < c.va);
    end
  endfunction

  function automatic obs_t model(cfg_t c, int kk, bit in_rst);
    obs_t e;
    int px, py, hx, hy, dl;
    bit pen, hen, fresh, hact, vact;
    e = '0;
    if (in_rst) begin
      e.hs = !c.pol;
      e.vs = !c.pol;
      return e;
    end
    pix_at(c, kk, px, py, pen);
    e.x  = px[9:0];
    e.y  = py[9:0];
    e.en = pen;
    e.tk = is_tick(c, kk);
    fresh = is_tick(c, kk - 1);
    e.ls = fresh && (px == 0);
    e.fs = fresh && (px == 0) && (py == 0);
    dl = (c.sdel == 0) ? 1 : c.sdel;
    pix_at(c, kk - dl, hx, hy, hen);
    hact = (hx >= c.ha + c.hf) && (hx < c.ha + c.hf + c.hs);
    vact = (hy >= c.va + c.vf) && (hy < c.va + c.vf + c.vs);
    e.hs = hact ? c.pol : !c.pol;
    e.vs = vact ? c.pol : !c.pol;
    return e;
  endfunction

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(string nm, obs_t act, obs_t exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s k=%0d actual x=%0d y=%0d en=%b hs=%b vs=%b tk=%b ls=%b fs=%b required x=%0d y=%0d en=%b hs=%b vs=%b tk=%b ls=%b fs=%b",
               nm, k, act.x, act.y, act.en, act.hs, act.vs, act.tk, act.ls, act.fs,
               exp.x, exp.y, exp.en, exp.hs, exp.vs, exp.tk, exp.ls, exp.fs);
    else
      n_pass++;
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s k=%0d actual %0d required %0d", nm, k, act, exp);
    else n_pass++;
  endtask

  task automatic check_all(bit in_rst);
    chk("dut_d", ob_d, model(cfg_d, k, in_rst));
    chk("dut_s", ob_s, model(cfg_s, k, in_rst));
    chk("dut_f", ob_f, model(cfg_f, k, in_rst));
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    #1;
    check_all(1'b0);
  endtask

  // Assert reset (asynchronously mid-cycle if async), hold n edges, release.
  task automatic hold_reset(int n, bit async);
    int dly;
    if (async) begin
      dly = $urandom_range(1, 2);
      #(dly);
    end else begin
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check_all(1'b1);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_all(1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    #1;
    check_all(1'b0);
  endtask

  function automatic vec_t mk(int kk, int xx, int yy, bit e, bit h, bit v, bit t, bit l, bit f);
    vec_t r;
    r.k    = kk;
    r.e.x  = xx[9:0];
    r.e.y  = yy[9:0];
    r.e.en = e;
    r.e.hs = h;
    r.e.vs = v;
    r.e.tk = t;
    r.e.ls = l;
    r.e.fs = f;
    return r;
  endfunction

  vec_t vec[16];

  initial begin
    int ls_cnt, n, k1, lines, run, prevx, len;
    bit found;

    cfg_d = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2};
    cfg_s = '{3, 8, 2, 3, 2, 5, 1, 2, 1, 1'b0, 2};
    cfg_f = '{1, 6, 1, 2, 1, 4, 1, 1, 2, 1'b1, 0};

    // Hand-derived expectations for the default 640x480 / div-4 instance.
    //           k     x    y  en hs vs tk ls fs
    vec[0]  = mk(0,    0,   0, 0, 1, 1, 0, 0, 0);
    vec[1]  = mk(3,    0,   0, 0, 1, 1, 1, 0, 0);
    vec[2]  = mk(4,    0,   0, 1, 1, 1, 0, 1, 1);
    vec[3]  = mk(5,    0,   0, 1, 1, 1, 0, 0, 0);
    vec[4]  = mk(7,    0,   0, 1, 1, 1, 1, 0, 0);
    vec[5]  = mk(8,    1,   0, 1, 1, 1, 0, 0, 0);
    vec[6]  = mk(2560, 639, 0, 1, 1, 1, 0, 0, 0);
    vec[7]  = mk(2564, 640, 0, 0, 1, 1, 0, 0, 0);
    vec[8]  = mk(2628, 656, 0, 0, 1, 1, 0, 0, 0);
    vec[9]  = mk(2630, 656, 0, 0, 0, 1, 0, 0, 0);
    vec[10] = mk(3013, 752, 0, 0, 0, 1, 0, 0, 0);
    vec[11] = mk(3014, 752, 0, 0, 1, 1, 0, 0, 0);
    vec[12] = mk(3200, 799, 0, 0, 1, 1, 0, 0, 0);
    vec[13] = mk(3203, 799, 0, 0, 1, 1, 1, 0, 0);
    vec[14] = mk(3204, 0,   1, 1, 1, 1, 0, 1, 0);
    vec[15] = mk(3205, 0,   1, 1, 1, 1, 0, 0, 0);

    // Reset held for 5 clks, then released.
    k = 0;
    repeat (5) @(posedge clk);
    #1;
    check_all(1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all(1'b0);

    // Table vectors across the first line of the default instance.
    ls_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while (k < vec[i].k) begin
        step();
        if (k >= 5 && ls_d) ls_cnt++;
      end
      chk($sformatf("vec%0d", i), ob_d, vec[i].e);
    end
    chk_int("line_start_once_per_line", ls_cnt, 1);

    // Frame period and line count on the shrunk instance (135 ticks x 3 clks).
    hold_reset(2, 1'b0);
    n = 0;
    while (!fs_s && n < 1000) begin step(); n++; end
    chk_int("first_frame_start_seen", int'(fs_s), 1);
    chk_int("frame_start_has_line_start", int'(ls_s), 1);
    k1 = k;
    lines = 0;
    n = 0;
    do begin
      step();
      n++;
      if (ls_s) lines++;
    end while (!fs_s && n < 2000);
    chk_int("frame_period_clks", k - k1, 405);
    chk_int("lines_per_frame", lines, 9);
    chk_int("frame_start_has_line_start2", int'(ls_s), 1);

    // hsync active width: 3 pixels x 3 clks; vsync: 2 lines x 15 px x 3 clks.
    n = 0;
    while (hs_s && n < 500) begin step(); n++; end
    run = 0;
    while (!hs_s && run < 200) begin step(); run++; end
    chk_int("hsync_low_clks", run, 9);
    n = 0;
    while (vs_s && n < 1000) begin step(); n++; end
    run = 0;
    while (!vs_s && run < 400) begin step(); run++; end
    chk_int("vsync_low_clks", run, 90);

    // Mid-frame reset while hsync is active: syncs must go straight inactive.
    n = 0;
    found = 1'b0;
    while (!found && n < 1000) begin
      step();
      n++;
      found = (!hs_s && y_s == 10'd2);
    end
    chk_int("hsync_active_before_reset", int'(hs_s), 0);
    hold_reset(3, 1'b1);

    // Divide-by-1 instance: tick is constant, x advances every clk.
    prevx = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk_int("div1_tick_high", int'(tk_f), 1);
      if (k >= 3) chk_int("div1_x_increments", int'(x_f), (prevx + 1) % 10);
      prevx = int'(x_f);
    end

    // Randomized run lengths and reset pulses, checked against the model.
    for (int s = 0; s < 15; s++) begin
      len = $urandom_range(20, 700);
      repeat (len) step();
      hold_reset($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    repeat ($urandom_range(50, 300)) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
